btb_tagged_2bc: RTL and testbench
=================================

// Module: btb_tagged_2bc
// PURPOSE
//  Parametrised, tagged, direct-mapped branch target buffer with a 2-bit saturating counter per entry.
//  It sits in IF0 next to the predecoder. Each cycle it looks up the fetch PC combinationally and returns pred_pc and pred_taken.
//  The EX-stage resolution bus (fact_*) updates it. Tags remove aliasing; per-entry counters replace global direction state.
// PARAMETERS
//  INDEX_WIDTH  8   entry index bits; depth = 2**INDEX_WIDTH; index = pc[INDEX_WIDTH+2:3] (8-byte fetch bundle)
//  TAG_WIDTH    12  tag bits; tag = pc[INDEX_WIDTH+TAG_WIDTH+2:INDEX_WIDTH+3]; INDEX_WIDTH+TAG_WIDTH <= 29
//  CTR_INIT     2   counter value on allocation for a conditional branch (2'b10 = weak taken)
// PORTS
//  clk               in   1   clock
//  rstn              in   1   asynchronous active-low reset
//  if0_allowin       in   1   IF0 accepts a new fetch PC (gates perf counting only)
//  fetch_pc          in   32  PC being fetched
//  pred_hit          out  1   valid entry with matching tag at fetch index
//  pred_taken        out  1   predicted taken
//  pred_pc           out  32  predicted next fetch PC
//  fact_valid        in   1   resolution bus valid
//  fact_pc           in   32  PC of resolved instruction
//  fact_tpc          in   32  resolved target
//  fact_btype        in   2   00 not branch, 01 uncond direct, 10 cond PC-relative, 11 indirect (uncond)
//  fact_taken        in   1   resolved direction
//  flush             in   1   invalidate all entries
//  predict_dir_fail  in   1   backend direction mispredict strobe (perf only)
//  predict_add_fail  in   1   backend target mispredict strobe (perf only)
// BEHAVIOUR
//  - Storage per entry: valid, tag, btype[1:0], ctr[1:0], target[31:0]. Valid and ctr are flops with async reset; tag, btype and target have no reset.
//  - Reset: all valid=0, all ctr=CTR_INIT. Outputs are combinational, so after reset pred_hit=0, pred_taken=0, pred_pc=seq.
//  - seq = fetch_pc[2] ? fetch_pc+4 : fetch_pc+8 (32-bit wrap).
//  - Lookup, zero latency: pred_hit = valid[i] && tag[i]==fetch tag.
//  - pred_taken = pred_hit && (btype[i][0] || ctr[i][1]). Uncond and indirect entries are always taken.
//  - pred_pc = pred_taken ? target[i] : seq.
//  - Update on posedge when fact_valid. Let h = hit at fact index:
//    * btype 00 && h: clear valid (alias cleanup). btype 00 && !h: no change.
//    * branch && h: ctr saturating +1 if taken, -1 if not (00<->11 clamp).
//      If taken, write target=fact_tpc. Always write btype.
//    * branch && !h && fact_taken: allocate (overwrites victim).
//      valid=1, tag, btype, target=fact_tpc; ctr=CTR_INIT for cond, 2'b11 for uncond/indirect.
//    * branch && !h && !fact_taken: no change.
//  - Write-after-read: a lookup in the same cycle as an update to the same index returns the pre-update entry.
//    The new content is visible the next cycle.
//  - flush: on posedge all valid=0; ctr untouched. flush and fact_valid in the same cycle: flush wins, the update is dropped.
//  - rstn low mid-update: the update is lost and state is forced to reset values asynchronously.
// CONFIGURATION
//  BTB_PERF_CNT_EN defined adds 32-bit outputs perf_lookup, perf_hit, perf_dir_fail, perf_add_fail. All reset to 0 and wrap.
//   perf_lookup and perf_hit increment when if0_allowin (and pred_hit, for perf_hit).
//   perf_dir_fail and perf_add_fail increment on their strobes. flush does not clear them.
//  BTB_PERF_CNT_EN undefined: these ports and counters do not exist; predict_*_fail are ignored. Prediction behaviour is identical.
// TESTING
//  - After reset, fetch_pc=0x1C000000: pred_hit=0, pred_taken=0, pred_pc=0x1C000008. fetch_pc=0x1C000004 gives pred_pc=0x1C000008.
//  - Update cond taken, fact_pc=0x1C000010, tpc=0x1C000100. Next cycle fetch 0x1C000010: hit=1, taken=1, pred_pc=0x1C000100.
//    Two not-taken updates bring ctr to 00: taken=0, pred_pc=0x1C000018.
//  - Uncond (01) taken allocate at 0x1C000020, then 3 not-taken updates: pred_taken stays 1, pred_pc=fact_tpc.
//  - Alias: entry at 0x1C000010, then fetch 0x1C000010 + (1<<(INDEX_WIDTH+3)): hit=0.
//    A not-taken update there leaves the original intact; a taken update replaces it.
//  - Update and lookup on the same index in one cycle: old prediction that cycle, new the next.
//  - flush together with fact_valid taken allocate: every index misses the next cycle.
//    With BTB_PERF_CNT_EN, 10 allowin cycles with 4 hits read perf_lookup=10, perf_hit=4.

Source files
------------

// File: rtl/btb_tagged_2bc.sv
// rtl/btb_tagged_2bc.sv - tagged direct-mapped BTB with per-entry 2-bit saturating counters
// Optional BTB_PERF_CNT_EN adds lookup/hit/mispredict performance counters.
module btb_tagged_2bc #(
    parameter int         INDEX_WIDTH = 8,
    parameter int         TAG_WIDTH   = 12,
    parameter logic [1:0] CTR_INIT    = 2'b10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if0_allowin,
    input  logic [31:0] fetch_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic        fact_valid,
    input  logic [31:0] fact_pc,
    input  logic [31:0] fact_tpc,
    input  logic [1:0]  fact_btype,
    input  logic        fact_taken,
    input  logic        flush,
    input  logic        predict_dir_fail,
    input  logic        predict_add_fail
`ifdef BTB_PERF_CNT_EN
    ,
    output logic [31:0] perf_lookup,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_dir_fail,
    output logic [31:0] perf_add_fail
`endif
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [1:0]           ctr_q    [DEPTH];
    logic [1:0]           ctr_d    [DEPTH];
    logic [TAG_WIDTH-1:0] tag_q    [DEPTH];
    logic [TAG_WIDTH-1:0] tag_d    [DEPTH];
    logic [1:0]           btype_q  [DEPTH];
    logic [1:0]           btype_d  [DEPTH];
    logic [31:0]          target_q [DEPTH];
    logic [31:0]          target_d [DEPTH];

    logic [INDEX_WIDTH-1:0] fetch_idx, fact_idx;
    logic [TAG_WIDTH-1:0]   fetch_tag, fact_tag;
    logic                   fact_hit;
    logic [31:0]            seq_pc;

    assign fetch_idx = fetch_pc[INDEX_WIDTH+2:3];
    assign fetch_tag = fetch_pc[INDEX_WIDTH+TAG_WIDTH+2:INDEX_WIDTH+3];
    assign fact_idx  = fact_pc[INDEX_WIDTH+2:3];
    assign fact_tag  = fact_pc[INDEX_WIDTH+TAG_WIDTH+2:INDEX_WIDTH+3];
    assign fact_hit  = valid_q[fact_idx] && (tag_q[fact_idx] == fact_tag);

    // Lookup reads only the _q state, so a same-cycle update is seen next cycle
    assign seq_pc     = fetch_pc + (fetch_pc[2] ? 32'd4 : 32'd8);
    assign pred_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign pred_taken = pred_hit && (btype_q[fetch_idx][0] || ctr_q[fetch_idx][1]);
    assign pred_pc    = pred_taken ? target_q[fetch_idx] : seq_pc;

    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        btype_d  = btype_q;
        target_d = target_q;
        if (flush) begin
            valid_d = '0;
        end else if (fact_valid) begin
            if (fact_btype == 2'b00) begin
                if (fact_hit) begin
                    valid_d[fact_idx] = 1'b0;
                end
            end else if (fact_hit) begin
                if (fact_taken) begin
                    ctr_d[fact_idx]    = (ctr_q[fact_idx] == 2'b11) ? 2'b11 : ctr_q[fact_idx] + 2'd1;
                    target_d[fact_idx] = fact_tpc;
                end else begin
                    ctr_d[fact_idx]    = (ctr_q[fact_idx] == 2'b00) ? 2'b00 : ctr_q[fact_idx] - 2'd1;
                end
                btype_d[fact_idx] = fact_btype;
            end else if (fact_taken) begin
                valid_d[fact_idx]  = 1'b1;
                tag_d[fact_idx]    = fact_tag;
                btype_d[fact_idx]  = fact_btype;
                target_d[fact_idx] = fact_tpc;
                ctr_d[fact_idx]    = (fact_btype == 2'b10) ? CTR_INIT : 2'b11;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Payload fields are only meaningful behind valid, so they carry no reset
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        btype_q  <= btype_d;
        target_q <= target_d;
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc, fact_pc};

`ifdef BTB_PERF_CNT_EN
    logic [31:0] perf_lookup_q, perf_lookup_d;
    logic [31:0] perf_hit_q, perf_hit_d;
    logic [31:0] perf_dir_fail_q, perf_dir_fail_d;
    logic [31:0] perf_add_fail_q, perf_add_fail_d;

    always_comb begin
        perf_lookup_d   = perf_lookup_q   + {31'd0, if0_allowin};
        perf_hit_d      = perf_hit_q      + {31'd0, if0_allowin && pred_hit};
        perf_dir_fail_d = perf_dir_fail_q + {31'd0, predict_dir_fail};
        perf_add_fail_d = perf_add_fail_q + {31'd0, predict_add_fail};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_lookup_q   <= '0;
            perf_hit_q      <= '0;
            perf_dir_fail_q <= '0;
            perf_add_fail_q <= '0;
        end else begin
            perf_lookup_q   <= perf_lookup_d;
            perf_hit_q      <= perf_hit_d;
            perf_dir_fail_q <= perf_dir_fail_d;
            perf_add_fail_q <= perf_add_fail_d;
        end
    end

    assign perf_lookup   = perf_lookup_q;
    assign perf_hit      = perf_hit_q;
    assign perf_dir_fail = perf_dir_fail_q;
    assign perf_add_fail = perf_add_fail_q;
`else
    logic unused_perf_in;
    assign unused_perf_in = ^{if0_allowin, predict_dir_fail, predict_add_fail};
`endif

endmodule

// File: tb/tb_btb_tagged_2bc.sv
// tb/tb_btb_tagged_2bc.sv - directed and randomized checks of btb_tagged_2bc against a reference model
module tb_btb_tagged_2bc;

    logic        clk;
    logic        rstn;
    logic        if0_allowin;
    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        fact_valid;
    logic [31:0] fact_pc;
    logic [31:0] fact_tpc;
    logic [1:0]  fact_btype;
    logic        fact_taken;
    logic        flush;
    logic        predict_dir_fail;
    logic        predict_add_fail;
`ifdef BTB_PERF_CNT_EN
    logic [31:0] perf_lookup, perf_hit, perf_dir_fail, perf_add_fail;
`endif

    int tests;
    int fails;

    btb_tagged_2bc dut (
        .clk              (clk),
        .rstn             (rstn),
        .if0_allowin      (if0_allowin),
        .fetch_pc         (fetch_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_pc          (pred_pc),
        .fact_valid       (fact_valid),
        .fact_pc          (fact_pc),
        .fact_tpc         (fact_tpc),
        .fact_btype       (fact_btype),
        .fact_taken       (fact_taken),
        .flush            (flush),
        .predict_dir_fail (predict_dir_fail),
        .predict_add_fail (predict_add_fail)
`ifdef BTB_PERF_CNT_EN
        ,
        .perf_lookup      (perf_lookup),
        .perf_hit         (perf_hit),
        .perf_dir_fail    (perf_dir_fail),
        .perf_add_fail    (perf_add_fail)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one record per index, direction counter kept as an integer 0..3
    bit          m_valid [256];
    int unsigned m_tag   [256];
    int          m_btype [256];
    int          m_ctr   [256];
    logic [31:0] m_tgt   [256];
    int unsigned e_lookup, e_hit, e_dir, e_add;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 3) % 256);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc >> 11) % 4096;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 2;
        end
        e_lookup = 0; e_hit = 0; e_dir = 0; e_add = 0;
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output bit h, output bit t,
                                          output logic [31:0] npc);
        int i;
        i   = idx_of(pc);
        h   = m_valid[i] && (m_tag[i] == tag_of(pc));
        t   = h && ((m_btype[i] != 2) || (m_ctr[i] >= 2));
        npc = t ? m_tgt[i] : (pc[2] ? pc + 32'd4 : pc + 32'd8);
    endfunction

    function automatic void model_update();
        int i;
        bit h;
        i = idx_of(fact_pc);
        h = m_valid[i] && (m_tag[i] == tag_of(fact_pc));
        if (flush) begin
            for (int k = 0; k < 256; k++) m_valid[k] = 1'b0;
        end else if (fact_valid) begin
            if (fact_btype == 2'd0) begin
                if (h) m_valid[i] = 1'b0;
            end else if (h) begin
                if (fact_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = fact_tpc;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
                m_btype[i] = int'(fact_btype);
            end else if (fact_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(fact_pc);
                m_btype[i] = int'(fact_btype);
                m_tgt[i]   = fact_tpc;
                m_ctr[i]   = (fact_btype == 2'd2) ? 2 : 3;
            end
        end
    endfunction

    // Advance one clock; model follows the inputs seen at the edge, inputs change 1 ns later
    task automatic tick();
        bit h, t;
        logic [31:0] p;
        @(posedge clk);
        if (rstn) begin
            model_predict(fetch_pc, h, t, p);
            if (if0_allowin) begin
                e_lookup++;
                if (h) e_hit++;
            end
            if (predict_dir_fail) e_dir++;
            if (predict_add_fail) e_add++;
            model_update();
        end
        #1;
    endtask

    task automatic fact(input logic [31:0] pc, input logic [31:0] tpc, input logic [1:0] bt,
                        input logic tk);
        fact_valid = 1'b1; fact_pc = pc; fact_tpc = tpc; fact_btype = bt; fact_taken = tk;
        tick();
        fact_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_reset();
        fetch_pc = 32'h1C00_0000;
        #1;
        tests++;
        if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_pc !== 32'h1C00_0008) begin
            fails++;
            $display("FAIL reset_in_reset got hit=%b taken=%b pc=%h want 0 0 1c000008", pred_hit, pred_taken, pred_pc);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        fetch_pc = 32'h1C00_0000;
        #1;
        tests++;
        if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_pc !== 32'h1C00_0008) begin
            fails++;
            $display("FAIL reset_pc0 got hit=%b taken=%b pc=%h want 0 0 1c000008", pred_hit, pred_taken, pred_pc);
        end
        fetch_pc = 32'h1C00_0004;
        #1;
        tests++;
        if (pred_hit !== 1'b0 || pred_pc !== 32'h1C00_0008) begin
            fails++;
            $display("FAIL reset_pc4 got hit=%b pc=%h want 0 1c000008", pred_hit, pred_pc);
        end
        fetch_pc = 32'hFFFF_FFFC;
        #1;
        tests++;
        if (pred_pc !== 32'h0000_0000) begin
            fails++;
            $display("FAIL seq_wrap got pc=%h want 00000000", pred_pc);
        end
    endtask

    task automatic test_cond();
        fact(32'h1C00_0010, 32'h1C00_0100, 2'b10, 1'b1);
        fetch_pc = 32'h1C00_0010;
        #1;
        tests++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_pc !== 32'h1C00_0100) begin
            fails++;
            $display("FAIL cond_alloc got hit=%b taken=%b pc=%h want 1 1 1c000100", pred_hit, pred_taken, pred_pc);
        end
        fact(32'h1C00_0010, 32'h1C00_0100, 2'b10, 1'b0);
        fact(32'h1C00_0010, 32'h1C00_0100, 2'b10, 1'b0);
        #1;
        tests++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_pc !== 32'h1C00_0018) begin
            fails++;
            $display("FAIL cond_nt got hit=%b taken=%b pc=%h want 1 0 1c000018", pred_hit, pred_taken, pred_pc);
        end
    endtask

    task automatic test_uncond();
        fact(32'h1C00_0020, 32'h1C00_0400, 2'b01, 1'b1);
        repeat (3) fact(32'h1C00_0020, 32'h1C00_0400, 2'b01, 1'b0);
        fetch_pc = 32'h1C00_0020;
        #1;
        tests++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_pc !== 32'h1C00_0400) begin
            fails++;
            $display("FAIL uncond_sticky got hit=%b taken=%b pc=%h want 1 1 1c000400", pred_hit, pred_taken, pred_pc);
        end
    endtask

    task automatic test_alias();
        fetch_pc = 32'h1C00_0810;
        #1;
        tests++;
        if (pred_hit !== 1'b0 || pred_pc !== 32'h1C00_0818) begin
            fails++;
            $display("FAIL alias_miss got hit=%b pc=%h want 0 1c000818", pred_hit, pred_pc);
        end
        fact(32'h1C00_0810, 32'h1C00_0900, 2'b10, 1'b0);
        fetch_pc = 32'h1C00_0010;
        #1;
        tests++;
        if (pred_hit !== 1'b1) begin
            fails++;
            $display("FAIL alias_nt_keeps got hit=%b want 1", pred_hit);
        end
        fact(32'h1C00_0810, 32'h1C00_0900, 2'b10, 1'b1);
        #1;
        tests++;
        if (pred_hit !== 1'b0) begin
            fails++;
            $display("FAIL alias_replaced_old got hit=%b want 0", pred_hit);
        end
        fetch_pc = 32'h1C00_0810;
        #1;
        tests++;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_pc !== 32'h1C00_0900) begin
            fails++;
            $display("FAIL alias_replaced_new got hit=%b taken=%b pc=%h want 1 1 1c000900", pred_hit, pred_taken, pred_pc);
        end
    endtask

    task automatic test_back_to_back();
        fetch_pc = 32'h1C00_0030;
        fact_valid = 1'b1; fact_pc = 32'h1C00_0030; fact_tpc = 32'h1C00_0500;
        fact_btype = 2'b01; fact_taken = 1'b1;
        #1;
        tests++;
        if (pred_hit !== 1'b0 || pred_pc !== 32'h1C00_0038) begin
            fails++;
            $display("FAIL war_same_cycle got hit=%b pc=%h want 0 1c000038", pred_hit, pred_pc);
        end
        tick();
        fact_valid = 1'b0;
        #1;
        tests++;
        if (pred_hit !== 1'b1 || pred_pc !== 32'h1C00_0500) begin
            fails++;
            $display("FAIL war_next_cycle got hit=%b pc=%h want 1 1c000500", pred_hit, pred_pc);
        end
    endtask

    task automatic test_flush();
        logic [31:0] pcs [5];
        pcs[0] = 32'h1C00_0810; pcs[1] = 32'h1C00_0020; pcs[2] = 32'h1C00_0030;
        pcs[3] = 32'h1C00_0040; pcs[4] = 32'h1C00_0010;
        flush = 1'b1;
        fact(32'h1C00_0040, 32'h1C00_0600, 2'b01, 1'b1);
        flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            fetch_pc = pcs[k];
            #1;
            tests++;
            if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin
                fails++;
                $display("FAIL flush_miss pc=%h got hit=%b taken=%b want 0 0", pcs[k], pred_hit, pred_taken);
            end
        end
    endtask

    task automatic test_async_reset();
        fact(32'h1C00_0020, 32'h1C00_0400, 2'b01, 1'b1);
        fact_valid = 1'b1; fact_pc = 32'h1C00_0050; fact_tpc = 32'h1C00_0700;
        fact_btype = 2'b01; fact_taken = 1'b1;
        fetch_pc = 32'h1C00_0020;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        tests++;
        if (pred_hit !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_now got hit=%b want 0", pred_hit);
        end
        @(posedge clk);
        #3;
        rstn = 1'b1;
        fact_valid = 1'b0;
        tick();
        fetch_pc = 32'h1C00_0050;
        #1;
        tests++;
        if (pred_hit !== 1'b0 || pred_pc !== 32'h1C00_0058) begin
            fails++;
            $display("FAIL async_reset_update_lost got hit=%b pc=%h want 0 1c000058", pred_hit, pred_pc);
        end
    endtask

`ifdef BTB_PERF_CNT_EN
    task automatic test_perf();
        tests++;
        if (perf_lookup !== 32'd0 || perf_hit !== 32'd0) begin
            fails++;
            $display("FAIL perf_reset got lookup=%0d hit=%0d want 0 0", perf_lookup, perf_hit);
        end
        fact(32'h1C00_0060, 32'h1C00_0700, 2'b01, 1'b1);
        if0_allowin = 1'b1;
        for (int k = 0; k < 10; k++) begin
            fetch_pc = (k < 4) ? 32'h1C00_0060 : 32'h1C00_0068;
            predict_dir_fail = (k < 3);
            predict_add_fail = (k >= 8);
            tick();
        end
        if0_allowin = 1'b0; predict_dir_fail = 1'b0; predict_add_fail = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        tests++;
        if (perf_lookup !== 32'd10 || perf_hit !== 32'd4 || perf_dir_fail !== 32'd3 || perf_add_fail !== 32'd2) begin
            fails++;
            $display("FAIL perf_counts got lookup=%0d hit=%0d dir=%0d add=%0d want 10 4 3 2",
                     perf_lookup, perf_hit, perf_dir_fail, perf_add_fail);
        end
    endtask
`endif

    task automatic test_random();
        bit h, t;
        logic [31:0] p;
        int bad;
        bad = 0;
        for (int n = 0; n < 600; n++) begin
            fact_valid = ($urandom_range(0, 9) < 7);
            fact_pc    = 32'h1C00_0000 | ($urandom_range(0, 7) << 3) | ($urandom_range(0, 1) << 11)
                         | ($urandom_range(0, 1) << 2);
            fact_tpc   = $urandom & 32'hFFFF_FFFC;
            fact_btype = 2'($urandom_range(0, 3));
            fact_taken = $urandom_range(0, 1);
            flush      = ($urandom_range(0, 49) == 0);
            fetch_pc   = 32'h1C00_0000 | ($urandom_range(0, 7) << 3) | ($urandom_range(0, 1) << 11)
                         | ($urandom_range(0, 1) << 2);
            if0_allowin      = $urandom_range(0, 1);
            predict_dir_fail = $urandom_range(0, 1);
            predict_add_fail = $urandom_range(0, 1);
            #1;
            model_predict(fetch_pc, h, t, p);
            tests++;
            if (pred_hit !== h || pred_taken !== t || pred_pc !== p) begin
                fails++;
                if (bad < 10)
                    $display("FAIL random_lookup pc=%h got hit=%b taken=%b pc=%h want %b %b %h",
                             fetch_pc, pred_hit, pred_taken, pred_pc, h, t, p);
                bad++;
            end
            tick();
        end
        fact_valid = 1'b0; flush = 1'b0; if0_allowin = 1'b0;
        predict_dir_fail = 1'b0; predict_add_fail = 1'b0;
`ifdef BTB_PERF_CNT_EN
        #1;
        tests++;
        if (perf_lookup !== e_lookup || perf_hit !== e_hit || perf_dir_fail !== e_dir || perf_add_fail !== e_add) begin
            fails++;
            $display("FAIL random_perf got %0d %0d %0d %0d want %0d %0d %0d %0d", perf_lookup, perf_hit,
                     perf_dir_fail, perf_add_fail, e_lookup, e_hit, e_dir, e_add);
        end
`endif
    endtask

    initial begin
        tests = 0; fails = 0;
        if0_allowin = 1'b0; flush = 1'b0; fact_valid = 1'b0;
        fact_pc = '0; fact_tpc = '0; fact_btype = 2'b00; fact_taken = 1'b0;
        predict_dir_fail = 1'b0; predict_add_fail = 1'b0;
        fetch_pc = '0;
        for (int i = 0; i < 256; i++) begin
            m_tag[i] = 0; m_btype[i] = 0; m_tgt[i] = '0;
        end
        test_reset();
        test_cond();
        test_uncond();
        test_alias();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef BTB_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
